stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: TICKS_PER_SEC, 4, number of tick pulses per second; the 250 ms timer rollover gives 4; legal values are even and at least 2.
REQ-002 Port: clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: tick  input  1  one-clk-cycle pulse from the 250 ms timer rollover.
REQ-005 Port: start_stop  input  1  level from the debounced button; the block edge-detects it internally.
REQ-006 Port: clear  input  1  level; while high, the block is forced to the zeroed IDLE condition.
REQ-007 Port: sec_ones  output  4  BCD seconds units, 0-9.
REQ-008 Port: sec_tens  output  4  BCD seconds tens, 0-5.
REQ-009 Port: min_ones  output  4  BCD minutes units, 0-9.
REQ-010 Port: min_tens  output  4  BCD minutes tens, 0-5.
REQ-011 Port: running  output  1  high exactly while state is RUN.
REQ-012 Port: colon  output  1  display colon enable (blinks at 1 Hz while running).
REQ-013 Port: wrap  output  1  one-cycle pulse when the count rolls from 59:59 to 00:00.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE, held in a registered state variable.
REQ-015 start_rise SHALL be start_stop AND NOT start_stop_d, where start_stop_d is start_stop registered one cycle.
REQ-016 On start_rise, transitions SHALL be: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-017 clear high SHALL force the next state to IDLE and zero all digits and the quarter counter, with priority over start_rise and tick.
REQ-018 Quarter counter q (width ceil(log2(TICKS_PER_SEC))) SHALL increment on tick only when the current registered state is RUN.
REQ-019 When q = TICKS_PER_SEC-1 and a qualifying tick occurs, q SHALL go to 0 and the seconds SHALL increment by 1, in the same edge.
REQ-020 BCD carry chain: sec_ones 9->0 increments sec_tens; sec_tens 5 with sec_ones 9 ->00 increments min_ones; min_ones 9->0 increments min_tens; all carries resolve in the same edge.
REQ-021 At 59:59 with a seconds increment, all digits SHALL become 00:00, wrap SHALL pulse high for exactly 1 cycle, and the state SHALL stay RUN.
REQ-022 Latency: digit registers SHALL change on the clk edge that samples tick high, and the new value SHALL be visible in the following cycle.
REQ-023 A tick in the same cycle as an IDLE->RUN start_rise SHALL NOT be counted.
REQ-024 A tick in the same cycle as a RUN->PAUSE start_rise SHALL be counted.
REQ-025 PAUSE SHALL hold the digits and q unchanged; PAUSE->RUN SHALL resume from the held q, not from 0.
REQ-026 colon SHALL be 1 in IDLE and PAUSE; in RUN, colon SHALL be 1 when q < TICKS_PER_SEC/2 and 0 otherwise.
REQ-027 running and colon SHALL be combinational decodes of registered state and q only; all other outputs SHALL be registered.
REQ-028 Digit values outside the BCD range SHALL be unreachable.

Reset
REQ-029 reset SHALL put: state IDLE, q 0, all digits 0, wrap 0, running 0, colon 1.
REQ-030 reset SHALL set start_stop_d to 1, so that a button held through reset release does not start the stopwatch.
REQ-031 reset asserted mid-RUN SHALL take effect at the next clk edge and SHALL override clear, tick and start_rise.

Structure
REQ-032 The state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) and the BCD limits 9 and 5 SHALL live in the shared timers package/include, alongside the timer count constants.
REQ-033 A sub-module bcd_digit_cnt SHALL implement each digit: parameter MAX (9 or 5); inputs clk, reset, clr, inc; outputs digit[3:0] and carry, where carry = inc AND digit==MAX.
REQ-034 stopwatch_ctrl SHALL instantiate four bcd_digit_cnt and SHALL contain the FSM, the edge detector and q.

Verification (drive tick as a 1-cycle pulse every N clks; TICKS_PER_SEC=4)
REQ-035 Reset, pulse start_stop, then 4 ticks -> running=1, display 00:01, colon pattern 1,1,0,0 across the quarters.
REQ-036 RUN with 240 ticks -> display 01:00, no wrap pulse.
REQ-037 RUN with 14400 ticks -> at 59:59 plus the next second, display 00:00, wrap high for exactly 1 cycle, running still 1.
REQ-038 RUN, 6 ticks (q=2) -> press to PAUSE, 10 ticks -> display 00:01 held; press to RUN, 2 ticks -> display 00:02.
REQ-039 Start_rise coincident with tick: from IDLE, count stays 0 (q=0); from RUN at q=3, the seconds increment and the state goes to PAUSE.
REQ-040 clear asserted mid-RUN at 12:34 with tick and start_rise in the same cycle -> next cycle IDLE, 00:00, running=0, colon=1.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch/timer constants: FSM encoding, BCD digit limits and tick timing.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } sw_state_e;

    localparam int unsigned BcdMaxUnits = 9;
    localparam int unsigned BcdMaxTens  = 5;

    localparam int unsigned ClkHz           = 50_000_000;
    localparam int unsigned TickPeriodMs    = 250;
    localparam int unsigned TimerTickCycles = ClkHz / 1000 * TickPeriodMs;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter, 0..MAX, with same-cycle carry out to the next digit.
module bcd_digit_cnt #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    assign carry = inc && (digit == 4'(MAX));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            // >= rather than == keeps any out-of-range value self-correcting
            if (digit >= 4'(MAX)) begin
                digit <= 4'd0;
            end else begin
                digit <= digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: start/stop edge detect, IDLE/RUN/PAUSE FSM, quarter-second prescaler
// and a four-digit BCD chain.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       colon,
    output logic       wrap
);

    localparam int unsigned QW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [QW-1:0] QMax  = QW'(TICKS_PER_SEC - 1);
    localparam logic [QW-1:0] QHalf = QW'(TICKS_PER_SEC / 2);

    sw_state_e     state;
    logic [QW-1:0] q;
    logic          start_stop_d;
    logic          start_rise;
    logic          count_en;
    logic          sec_inc;
    logic          carry_so, carry_st, carry_mo, carry_mt;

    assign start_rise = start_stop && !start_stop_d;
    // Qualified on the registered state, so a tick alongside IDLE->RUN is not counted
    assign count_en   = tick && (state == StRun) && !clear;
    assign sec_inc    = count_en && (q == QMax);

    assign running = (state == StRun);
    assign colon   = (state != StRun) || (q < QHalf);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            q            <= '0;
            start_stop_d <= 1'b1;
            wrap         <= 1'b0;
        end else begin
            start_stop_d <= start_stop;
            wrap         <= carry_mt;
            if (clear) begin
                state <= StIdle;
                q     <= '0;
            end else begin
                if (count_en) begin
                    q <= (q == QMax) ? '0 : q + QW'(1);
                end
                if (start_rise) begin
                    case (state)
                        StIdle:  state <= StRun;
                        StRun:   state <= StPause;
                        StPause: state <= StRun;
                        default: state <= StIdle;
                    endcase
                end
            end
        end
    end

    bcd_digit_cnt #(.MAX(BcdMaxUnits)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (sec_inc),
        .digit (sec_ones),
        .carry (carry_so)
    );

    bcd_digit_cnt #(.MAX(BcdMaxTens)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (carry_so),
        .digit (sec_tens),
        .carry (carry_st)
    );

    bcd_digit_cnt #(.MAX(BcdMaxUnits)) u_min_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (carry_st),
        .digit (min_ones),
        .carry (carry_mo)
    );

    bcd_digit_cnt #(.MAX(BcdMaxTens)) u_min_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (carry_mo),
        .digit (min_tens),
        .carry (carry_mt)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table, corner sequences and a random run
// checked every cycle against an elapsed-quarters model.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, colon, wrap;

    int n_checks = 0;
    int n_fail   = 0;
    int wrap_seen = 0;

    // Model: state (0 idle, 1 run, 2 pause) and total quarters since last clear
    int m_state    = 0;
    int m_quarters = 0;
    bit m_prev     = 1'b1;
    bit m_wrap     = 1'b0;

    stopwatch_ctrl #(.TICKS_PER_SEC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .colon      (colon),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ss;
        bit          tk;
        bit          clr;
        logic [15:0] digits;
        bit          run;
        bit          col;
        bit          wr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [18:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, running, colon, wrap};
    endfunction

    function automatic logic [18:0] model_vec();
        int secs, mm, ss;
        logic [15:0] d;
        logic r, c;
        secs = m_quarters / 4;
        mm   = secs / 60;
        ss   = secs % 60;
        d    = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        r    = (m_state == 1);
        c    = (m_state != 1) || ((m_quarters % 4) < 2);
        return {d, r, c, m_wrap};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit ss, input bit tk, input bit clr);
        bit rise;
        if (rst) begin
            m_state = 0; m_quarters = 0; m_prev = 1'b1; m_wrap = 1'b0;
        end else begin
            rise   = ss && !m_prev;
            m_prev = ss;
            if (clr) begin
                m_state = 0; m_quarters = 0; m_wrap = 1'b0;
            end else begin
                m_wrap = 1'b0;
                if (tk && m_state == 1) begin
                    m_quarters++;
                    if (m_quarters == 3600 * 4) begin
                        m_quarters = 0;
                        m_wrap = 1'b1;
                    end
                end
                if (rise) m_state = (m_state == 1) ? 2 : 1;
            end
        end
    endtask

    // One clock with the given inputs; DUT is compared against the model after the edge
    task automatic step(input bit rst, input bit ss, input bit tk, input bit clr);
        reset = rst; start_stop = ss; tick = tk; clear = clr;
        @(posedge clk);
        model_step(rst, ss, tk, clr);
        #1;
        if (wrap) wrap_seen++;
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic add_vec(input bit rst, input bit ss, input bit tk, input bit clr,
                           input logic [15:0] d, input bit r, input bit c, input bit w);
        vec_t v;
        v.rst = rst; v.ss = ss; v.tk = tk; v.clr = clr;
        v.digits = d; v.run = r; v.col = c; v.wr = w;
        vecs.push_back(v);
    endtask

    initial begin
        bit r_rst, r_ss, r_tk, r_clr;

        //       rst ss tk clr  digits    run col wrap
        add_vec(1, 1, 0, 0, 16'h0000, 0, 1, 0); // reset with button held
        add_vec(0, 1, 0, 0, 16'h0000, 0, 1, 0); // held button does not start
        add_vec(0, 0, 0, 0, 16'h0000, 0, 1, 0);
        add_vec(0, 1, 1, 0, 16'h0000, 1, 1, 0); // start + tick: tick ignored
        add_vec(0, 0, 1, 0, 16'h0000, 1, 1, 0); // q=1
        add_vec(0, 0, 0, 0, 16'h0000, 1, 1, 0);
        add_vec(0, 0, 1, 0, 16'h0000, 1, 0, 0); // q=2
        add_vec(0, 0, 1, 0, 16'h0000, 1, 0, 0); // q=3
        add_vec(0, 0, 1, 0, 16'h0001, 1, 1, 0); // q=0, 00:01
        add_vec(0, 0, 1, 0, 16'h0001, 1, 1, 0);
        add_vec(0, 0, 1, 0, 16'h0001, 1, 0, 0);
        add_vec(0, 0, 1, 0, 16'h0001, 1, 0, 0); // q=3
        add_vec(0, 1, 1, 0, 16'h0002, 0, 1, 0); // stop + tick: counted, PAUSE
        add_vec(0, 0, 1, 0, 16'h0002, 0, 1, 0); // paused tick ignored
        add_vec(0, 1, 0, 0, 16'h0002, 1, 1, 0); // resume
        add_vec(0, 0, 1, 1, 16'h0000, 0, 1, 0); // clear beats tick
        add_vec(0, 1, 0, 0, 16'h0000, 1, 1, 0); // start
        add_vec(0, 0, 1, 0, 16'h0000, 1, 1, 0); // q=1
        add_vec(1, 1, 1, 1, 16'h0000, 0, 1, 0); // reset overrides everything
        add_vec(0, 0, 0, 0, 16'h0000, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ss, vecs[i].tk, vecs[i].clr);
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({vecs[i].digits, vecs[i].run, vecs[i].col, vecs[i].wr}));
        end

        // One minute of ticks: 01:00, no wrap
        do_reset();
        press();
        wrap_seen = 0;
        tick_n(240);
        check("one_minute", 32'({min_tens, min_ones, sec_tens, sec_ones, running}),
              32'({16'h0100, 1'b1}));
        check("one_minute_wrap", 32'(wrap_seen), 32'd0);

        // Full hour: 59:59 then rollover with a single wrap pulse
        do_reset();
        press();
        wrap_seen = 0;
        tick_n(3599 * 4);
        check("at_5959", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h5959);
        tick_n(4);
        check("rollover", 32'({min_tens, min_ones, sec_tens, sec_ones, running}),
              32'({16'h0000, 1'b1}));
        check("wrap_cycles", 32'(wrap_seen), 32'd1);

        // Pause holds q and digits; resume continues from held q
        do_reset();
        press();
        tick_n(6);
        press();
        tick_n(10);
        check("paused", 32'({min_tens, min_ones, sec_tens, sec_ones, running}),
              32'({16'h0001, 1'b0}));
        press();
        tick_n(2);
        check("resumed", 32'({min_tens, min_ones, sec_tens, sec_ones, running}),
              32'({16'h0002, 1'b1}));

        // clear at 12:34 alongside tick and start_rise
        do_reset();
        press();
        tick_n(754 * 4);
        check("at_1234", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h1234);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_prio", 32'(dut_vec()), 32'({16'h0000, 1'b0, 1'b1, 1'b0}));

        // Random run against the model
        do_reset();
        r_ss = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 799) == 0);
            r_clr = ($urandom_range(0, 299) == 0);
            r_tk  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 14) == 0) r_ss = ~r_ss;
            step(r_rst, r_ss, r_tk, r_clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
